// File: rtl/aoc_pkg.sv
// Shared definitions for the range/group arithmetic blocks: FSM state type,
// the power-of-ten table and a combinational digit-count helper.
`ifndef DATA_WIDTH
`define DATA_WIDTH 64
`endif
`ifndef LONG_DATA_WIDTH
`define LONG_DATA_WIDTH 64
`endif

package aoc_pkg;

  // Digit counters and table indices; covers digit counts up to 31.
  localparam int unsigned DIGIT_W = 5;

  // Highest power of ten held in the table (10^19 still fits in 64 bits).
  // Users must keep MAX_DIGITS at or below this value.
  localparam int unsigned POW10_LAST = 19;

  typedef enum logic [2:0] {
    StIdle,
    StDigits,
    StBase,
    StDivLo,
    StDivHi,
    StAccum,
    StNextD,
    StDone
  } group_range_state_t;

  localparam logic [63:0] POW10 [0:POW10_LAST] = '{
    64'd1,
    64'd10,
    64'd100,
    64'd1000,
    64'd10000,
    64'd100000,
    64'd1000000,
    64'd10000000,
    64'd100000000,
    64'd1000000000,
    64'd10000000000,
    64'd100000000000,
    64'd1000000000000,
    64'd10000000000000,
    64'd100000000000000,
    64'd1000000000000000,
    64'd10000000000000000,
    64'd100000000000000000,
    64'd1000000000000000000,
    64'd10000000000000000000
  };

  // Decimal digit count of x; zero counts as one digit.
  function automatic logic [DIGIT_W-1:0] digits(input logic [63:0] x);
    logic [DIGIT_W-1:0] n;
    n = DIGIT_W'(1);
    for (int i = 1; i <= int'(POW10_LAST); i++) begin
      if (x >= POW10[i]) n = n + DIGIT_W'(1);
    end
    return n;
  endfunction

endpackage

// File: rtl/seq_div.sv
// Restoring unsigned divider, one quotient bit per cycle. A start pulse loads
// the operands; done pulses for one cycle exactly DATA_W+1 cycles later with
// quot valid at that point. A new start may be issued in the done cycle.
module seq_div #(
  parameter int unsigned DATA_W = 64
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] num,
  input  logic [DATA_W-1:0] den,
  output logic              done,
  output logic [DATA_W-1:0] quot
);

  localparam int unsigned CNT_W = $clog2(DATA_W + 1);

  logic              busy_q;
  logic              done_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [DATA_W:0]   rem_q;
  logic [DATA_W-1:0] quot_q;
  logic [DATA_W-1:0] den_q;
  logic [DATA_W:0]   shifted;
  logic [DATA_W:0]   diff;

  // Trial subtraction of the divisor from the shifted partial remainder.
  always_comb begin
    shifted = {rem_q[DATA_W-1:0], quot_q[DATA_W-1]};
    diff    = shifted - {1'b0, den_q};
  end

  // Load on start, then shift/subtract once per cycle until all bits resolved.
  always_ff @(posedge clock) begin
    if (reset) begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
      cnt_q  <= '0;
      rem_q  <= '0;
      quot_q <= '0;
      den_q  <= '0;
    end else begin
      done_q <= 1'b0;
      if (start) begin
        busy_q <= 1'b1;
        cnt_q  <= CNT_W'(DATA_W);
        rem_q  <= '0;
        quot_q <= num;
        den_q  <= den;
      end else if (busy_q) begin
        // Sign bit of diff clear means the divisor fits: keep the difference.
        if (!diff[DATA_W]) begin
          rem_q  <= diff;
          quot_q <= {quot_q[DATA_W-2:0], 1'b1};
        end else begin
          rem_q  <= shifted;
          quot_q <= {quot_q[DATA_W-2:0], 1'b0};
        end
        cnt_q <= cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          busy_q <= 1'b0;
          done_q <= 1'b1;
        end
      end
    end
  end

  assign done = done_q;
  assign quot = quot_q;

endmodule

// File: rtl/group_range_sum.sv
// Sums every integer in [lo, hi] whose decimal form is one block repeated
// exactly REPS times. For each digit count d divisible by REPS the matches
// are x*m with m = sum 10^(i*b), b = d/REPS, so the sum is m times an
// arithmetic series over the legal block range [xl, xh].
// Optional feature macro: GROUP_RANGE_COUNT_EN adds count_out (match count).
`ifndef DATA_WIDTH
`define DATA_WIDTH 64
`endif
`ifndef LONG_DATA_WIDTH
`define LONG_DATA_WIDTH 64
`endif

module group_range_sum
  import aoc_pkg::*;
#(
  parameter int unsigned DATA_W     = `DATA_WIDTH,
  parameter int unsigned SUM_W      = `LONG_DATA_WIDTH,
  parameter int unsigned REPS       = 2,
  parameter int unsigned MAX_DIGITS = 10
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] lo_in,
  input  logic [DATA_W-1:0] hi_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [SUM_W-1:0]  sum_out,
`ifdef GROUP_RANGE_COUNT_EN
  output logic [DATA_W-1:0] count_out,
`endif
  output logic              err_out
);

  group_range_state_t state_q, state_d;

  logic [DATA_W-1:0]  lo_q, lo_d, hi_q, hi_d;
  logic [DIGIT_W-1:0] scan_q, scan_d, dl_q, dl_d, dh_q, dh_d;
  logic [DIGIT_W-1:0] d_q, d_d, b_q, b_d, idx_q, idx_d, rep_q, rep_d;
  logic [DATA_W-1:0]  m_q, m_d, xl_q, xl_d, xh_q, xh_d;
  logic [SUM_W-1:0]   acc_q, acc_d;
  logic               err_q, err_d;
`ifdef GROUP_RANGE_COUNT_EN
  logic [DATA_W-1:0]  cnt_q, cnt_d;
`endif

  logic               div_start, div_done;
  logic [DATA_W-1:0]  div_num, div_den, div_quot;
  logic               load_d;
  logic [DIGIT_W-1:0] d_new;
  logic [DATA_W-1:0]  m_sum, lim;
  logic [SUM_W-1:0]   s_m, s_xl, s_xh, s_tri;

  function automatic logic [DATA_W-1:0] p10(input logic [DIGIT_W-1:0] i);
    return DATA_W'(POW10[i]);
  endfunction

  seq_div #(
    .DATA_W(DATA_W)
  ) u_div (
    .clock(clock),
    .reset(reset),
    .start(div_start),
    .num  (div_num),
    .den  (div_den),
    .done (div_done),
    .quot (div_quot)
  );

  // Next-state and datapath updates; every target defaults to hold.
  always_comb begin
    state_d   = state_q;
    lo_d      = lo_q;
    hi_d      = hi_q;
    scan_d    = scan_q;
    dl_d      = dl_q;
    dh_d      = dh_q;
    d_d       = d_q;
    b_d       = b_q;
    idx_d     = idx_q;
    rep_d     = rep_q;
    m_d       = m_q;
    xl_d      = xl_q;
    xh_d      = xh_q;
    acc_d     = acc_q;
    err_d     = err_q;
`ifdef GROUP_RANGE_COUNT_EN
    cnt_d     = cnt_q;
`endif
    div_start = 1'b0;
    div_num   = '0;
    div_den   = '0;
    load_d    = 1'b0;
    d_new     = '0;
    m_sum     = m_q + p10(idx_q);
    lim       = '0;
    s_m       = SUM_W'(m_q);
    s_xl      = SUM_W'(xl_q);
    s_xh      = SUM_W'(xh_q);
    s_tri     = ((s_xl + s_xh) * (s_xh - s_xl + SUM_W'(1))) >> 1;

    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          lo_d   = (lo_in == '0) ? DATA_W'(1) : lo_in;
          hi_d   = hi_in;
          acc_d  = '0;
          err_d  = 1'b0;
          scan_d = '0;
          dl_d   = '0;
`ifdef GROUP_RANGE_COUNT_EN
          cnt_d  = '0;
`endif
          state_d = StDigits;
        end
      end
      // Cycle j tests 10^j; the first j with hi < 10^j gives digits(hi) = j.
      StDigits: begin
        if (lo_q >= p10(scan_q)) dl_d = scan_q + DIGIT_W'(1);
        if (hi_q < p10(scan_q)) begin
          dh_d = scan_q;
          if (lo_q > hi_q) begin
            state_d = StDone;
          end else begin
            load_d = 1'b1;
            d_new  = dl_q;
          end
        end else if (scan_q == DIGIT_W'(MAX_DIGITS)) begin
          err_d   = 1'b1;
          state_d = StDone;
        end else begin
          scan_d = scan_q + DIGIT_W'(1);
        end
      end
      // One term of m per cycle; the last term also launches the lo division.
      StBase: begin
        m_d   = m_sum;
        idx_d = idx_q + b_q;
        rep_d = rep_q + DIGIT_W'(1);
        if (32'(rep_q) == REPS - 32'd1) begin
          div_start = 1'b1;
          div_num   = lo_q + m_sum - DATA_W'(1);
          div_den   = m_sum;
          state_d   = StDivLo;
        end
      end
      StDivLo: begin
        if (div_done) begin
          lim       = p10(b_q - DIGIT_W'(1));
          xl_d      = (div_quot > lim) ? div_quot : lim;
          div_start = 1'b1;
          div_num   = hi_q;
          div_den   = m_q;
          state_d   = StDivHi;
        end
      end
      StDivHi: begin
        if (div_done) begin
          lim     = p10(b_q) - DATA_W'(1);
          xh_d    = (div_quot < lim) ? div_quot : lim;
          state_d = StAccum;
        end
      end
      StAccum: begin
        if (xl_q <= xh_q) begin
          acc_d = acc_q + s_m * s_tri;
`ifdef GROUP_RANGE_COUNT_EN
          cnt_d = cnt_q + (xh_q - xl_q + DATA_W'(1));
`endif
        end
        state_d = StNextD;
      end
      StNextD: begin
        if (d_q == dh_q) begin
          state_d = StDone;
        end else begin
          load_d = 1'b1;
          d_new  = d_q + DIGIT_W'(1);
        end
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Enter a digit count: digit counts not divisible by REPS are skipped.
    if (load_d) begin
      d_d = d_new;
      if ((32'(d_new) % REPS) == 32'd0) begin
        b_d     = DIGIT_W'(32'(d_new) / REPS);
        idx_d   = '0;
        rep_d   = '0;
        m_d     = '0;
        state_d = StBase;
      end else begin
        state_d = StNextD;
      end
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StIdle;
      lo_q    <= '0;
      hi_q    <= '0;
      scan_q  <= '0;
      dl_q    <= '0;
      dh_q    <= '0;
      d_q     <= '0;
      b_q     <= '0;
      idx_q   <= '0;
      rep_q   <= '0;
      m_q     <= '0;
      xl_q    <= '0;
      xh_q    <= '0;
      acc_q   <= '0;
      err_q   <= 1'b0;
`ifdef GROUP_RANGE_COUNT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      scan_q  <= scan_d;
      dl_q    <= dl_d;
      dh_q    <= dh_d;
      d_q     <= d_d;
      b_q     <= b_d;
      idx_q   <= idx_d;
      rep_q   <= rep_d;
      m_q     <= m_d;
      xl_q    <= xl_d;
      xh_q    <= xh_d;
      acc_q   <= acc_d;
      err_q   <= err_d;
`ifdef GROUP_RANGE_COUNT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign sum_out   = acc_q;
  assign err_out   = err_q;
`ifdef GROUP_RANGE_COUNT_EN
  assign count_out = cnt_q;
`endif

endmodule

// File: tb/tb_group_range_sum.sv
// Scoreboard bench: dut_a runs REPS=2, dut_b runs REPS=3.
module tb_group_range_sum;

  logic        clock = 1'b0;
  logic        reset;
  logic [63:0] lo_in, hi_in;
  logic        in_valid_a, in_ready_a, out_valid_a, out_ready_a, err_a;
  logic        in_valid_b, in_ready_b, out_valid_b, out_ready_b, err_b;
  logic [63:0] sum_a, sum_b;
`ifdef GROUP_RANGE_COUNT_EN
  logic [63:0] cnt_a, cnt_b;
`endif

  typedef struct {
    logic [63:0] sum;
    logic        err;
    logic [63:0] cnt;
  } exp_t;

  exp_t sb_a[$];
  exp_t sb_b[$];
  int   total = 0;
  int   bad = 0;

  always #5 clock = ~clock;

  group_range_sum #(.DATA_W(64), .SUM_W(64), .REPS(2), .MAX_DIGITS(10)) dut_a (
    .clock    (clock),
    .reset    (reset),
    .in_valid (in_valid_a),
    .in_ready (in_ready_a),
    .lo_in    (lo_in),
    .hi_in    (hi_in),
    .out_valid(out_valid_a),
    .out_ready(out_ready_a),
    .sum_out  (sum_a),
`ifdef GROUP_RANGE_COUNT_EN
    .count_out(cnt_a),
`endif
    .err_out  (err_a)
  );

  group_range_sum #(.DATA_W(64), .SUM_W(64), .REPS(3), .MAX_DIGITS(10)) dut_b (
    .clock    (clock),
    .reset    (reset),
    .in_valid (in_valid_b),
    .in_ready (in_ready_b),
    .lo_in    (lo_in),
    .hi_in    (hi_in),
    .out_valid(out_valid_b),
    .out_ready(out_ready_b),
    .sum_out  (sum_b),
`ifdef GROUP_RANGE_COUNT_EN
    .count_out(cnt_b),
`endif
    .err_out  (err_b)
  );

  // Brute-force reference: test every integer for exact REPS repetition.
  function automatic longint unsigned ref_sum(input longint unsigned lo, input longint unsigned hi,
                                              input int reps, output longint unsigned cnt);
    longint unsigned s, n, t, p, m, start;
    int d, b;
    s = 0;
    cnt = 0;
    start = (lo == 0) ? 1 : lo;
    for (n = start; n <= hi; n++) begin
      d = 0;
      t = n;
      while (t != 0) begin
        t = t / 10;
        d++;
      end
      if (d % reps == 0) begin
        b = d / reps;
        p = 1;
        for (int i = 0; i < b; i++) p = p * 10;
        m = 0;
        t = 1;
        for (int i = 0; i < reps; i++) begin
          m = m + t;
          t = t * p;
        end
        if (n == (n % p) * m) begin
          s = s + n;
          cnt = cnt + 1;
        end
      end
    end
    return s;
  endfunction

  task automatic drive_req(input bit sel, input logic [63:0] lo, input logic [63:0] hi,
                           output bit ok);
    int n = 0;
    @(negedge clock);
    lo_in = lo;
    hi_in = hi;
    if (sel) in_valid_b = 1'b1;
    else in_valid_a = 1'b1;
    while (!(sel ? in_ready_b : in_ready_a) && n < 3000) begin
      @(negedge clock);
      n++;
    end
    ok = sel ? in_ready_b : in_ready_a;
    @(negedge clock);
    in_valid_a = 1'b0;
    in_valid_b = 1'b0;
  endtask

  // Waits for out_valid (out_ready already high) and captures the result.
  task automatic wait_result(input bit sel, output logic [63:0] sum, output logic err,
                             output logic [63:0] cnt, output bit ok);
    int n = 0;
    while (!(sel ? out_valid_b : out_valid_a) && n < 3000) begin
      @(negedge clock);
      n++;
    end
    ok  = sel ? out_valid_b : out_valid_a;
    sum = sel ? sum_b : sum_a;
    err = sel ? err_b : err_a;
    cnt = 64'd0;
`ifdef GROUP_RANGE_COUNT_EN
    cnt = sel ? cnt_b : cnt_a;
`endif
    @(negedge clock);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    total++;
    if ({in_ready_a, out_valid_a, err_a} !== 3'b100 || sum_a !== 64'd0) begin
      bad++;
      $display("FAIL reset_a: got rdy/vld/err=%b%b%b sum=%0d, expected 100 sum=0",
               in_ready_a, out_valid_a, err_a, sum_a);
    end
    total++;
    if ({in_ready_b, out_valid_b, err_b} !== 3'b100 || sum_b !== 64'd0) begin
      bad++;
      $display("FAIL reset_b: got rdy/vld/err=%b%b%b sum=%0d, expected 100 sum=0",
               in_ready_b, out_valid_b, err_b, sum_b);
    end
`ifdef GROUP_RANGE_COUNT_EN
    total++;
    if (cnt_a !== 64'd0) begin
      bad++;
      $display("FAIL reset_cnt: got %0d, expected 0", cnt_a);
    end
`endif
    reset = 1'b0;
  endtask

  task automatic test_ranges_reps2();
    logic [63:0] t_lo  [10] = '{64'd11, 64'd95, 64'd998, 64'd1188511880, 64'd1698522, 64'd50,
                               64'd1, 64'd0, 64'd1, 64'd1};
    logic [63:0] t_hi  [10] = '{64'd22, 64'd115, 64'd1012, 64'd1188511890, 64'd1698528, 64'd20,
                               64'd10000000000, 64'd0, 64'd9, 64'd99};
    logic [63:0] t_sum [10] = '{64'd33, 64'd99, 64'd1010, 64'd1188511885, 64'd0, 64'd0,
                               64'd0, 64'd0, 64'd0, 64'd495};
    logic        t_err [10] = '{0, 0, 0, 0, 0, 0, 1, 0, 0, 0};
    logic [63:0] t_cnt [10] = '{64'd2, 64'd1, 64'd1, 64'd1, 64'd0, 64'd0, 64'd0, 64'd0, 64'd0,
                               64'd9};
    exp_t e, g;
    bit ok;
    for (int i = 0; i < 10; i++) begin
      e.sum = t_sum[i];
      e.err = t_err[i];
      e.cnt = t_cnt[i];
      sb_a.push_back(e);
      drive_req(1'b0, t_lo[i], t_hi[i], ok);
      wait_result(1'b0, g.sum, g.err, g.cnt, ok);
      e = sb_a.pop_front();
      total++;
      if (!ok) begin
        bad++;
        $display("FAIL r2_timeout[%0d]: got no out_valid, expected a result", i);
      end else begin
        if (g.sum !== e.sum || g.err !== e.err) begin
          bad++;
          $display("FAIL r2_sum[%0d] %0d..%0d: got sum=%0d err=%0d, expected sum=%0d err=%0d",
                   i, t_lo[i], t_hi[i], g.sum, g.err, e.sum, e.err);
        end
`ifdef GROUP_RANGE_COUNT_EN
        total++;
        if (g.cnt !== e.cnt) begin
          bad++;
          $display("FAIL r2_cnt[%0d]: got %0d, expected %0d", i, g.cnt, e.cnt);
        end
`endif
      end
    end
  endtask

  task automatic test_ranges_reps3();
    logic [63:0] t_lo  [3] = '{64'd95, 64'd1, 64'd1};
    logic [63:0] t_hi  [3] = '{64'd115, 64'd999, 64'd99};
    logic [63:0] t_sum [3] = '{64'd111, 64'd4995, 64'd0};
    logic [63:0] t_cnt [3] = '{64'd1, 64'd9, 64'd0};
    exp_t e, g;
    bit ok;
    for (int i = 0; i < 3; i++) begin
      e.sum = t_sum[i];
      e.err = 1'b0;
      e.cnt = t_cnt[i];
      sb_b.push_back(e);
      drive_req(1'b1, t_lo[i], t_hi[i], ok);
      wait_result(1'b1, g.sum, g.err, g.cnt, ok);
      e = sb_b.pop_front();
      total++;
      if (!ok) begin
        bad++;
        $display("FAIL r3_timeout[%0d]: got no out_valid, expected a result", i);
      end else begin
        if (g.sum !== e.sum || g.err !== e.err) begin
          bad++;
          $display("FAIL r3_sum[%0d]: got sum=%0d err=%0d, expected sum=%0d err=%0d",
                   i, g.sum, g.err, e.sum, e.err);
        end
`ifdef GROUP_RANGE_COUNT_EN
        total++;
        if (g.cnt !== e.cnt) begin
          bad++;
          $display("FAIL r3_cnt[%0d]: got %0d, expected %0d", i, g.cnt, e.cnt);
        end
`endif
      end
    end
  endtask

  task automatic test_random();
    longint unsigned lo, hi, c;
    exp_t e, g;
    bit ok;
    for (int i = 0; i < 6; i++) begin
      lo = 64'($urandom_range(1, 3000));
      hi = lo + 64'($urandom_range(0, 1500));
      e.sum = ref_sum(lo, hi, 2, c);
      e.err = 1'b0;
      e.cnt = c;
      sb_a.push_back(e);
      drive_req(1'b0, lo, hi, ok);
      wait_result(1'b0, g.sum, g.err, g.cnt, ok);
      e = sb_a.pop_front();
      total++;
      if (!ok || g.sum !== e.sum || g.err !== e.err) begin
        bad++;
        $display("FAIL rand[%0d] %0d..%0d: got vld=%0d sum=%0d err=%0d, expected sum=%0d err=0",
                 i, lo, hi, ok, g.sum, g.err, e.sum);
      end
`ifdef GROUP_RANGE_COUNT_EN
      total++;
      if (g.cnt !== e.cnt) begin
        bad++;
        $display("FAIL rand_cnt[%0d]: got %0d, expected %0d", i, g.cnt, e.cnt);
      end
`endif
    end
  endtask

  task automatic test_backpressure();
    exp_t e;
    bit ok;
    int n = 0;
    e.sum = 64'd222222;
    e.err = 1'b0;
    e.cnt = 64'd1;
    sb_a.push_back(e);
    out_ready_a = 1'b0;
    drive_req(1'b0, 64'd222220, 64'd222224, ok);
    while (!out_valid_a && n < 3000) begin
      @(negedge clock);
      n++;
    end
    e = sb_a.pop_front();
    for (int i = 0; i < 5; i++) begin
      total++;
      if (out_valid_a !== 1'b1 || sum_a !== e.sum || err_a !== 1'b0 || in_ready_a !== 1'b0) begin
        bad++;
        $display("FAIL hold[%0d]: got vld=%b sum=%0d err=%b rdy=%b, expected vld=1 sum=%0d err=0 rdy=0",
                 i, out_valid_a, sum_a, err_a, in_ready_a, e.sum);
      end
      @(negedge clock);
    end
    out_ready_a = 1'b1;
    @(negedge clock);
    total++;
    if (in_ready_a !== 1'b1 || out_valid_a !== 1'b0) begin
      bad++;
      $display("FAIL release: got rdy=%b vld=%b, expected rdy=1 vld=0", in_ready_a, out_valid_a);
    end
  endtask

  task automatic test_reset_mid();
    exp_t e, g;
    bit ok;
    drive_req(1'b0, 64'd11, 64'd22, ok);
    repeat (20) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    total++;
    if (in_ready_a !== 1'b1 || out_valid_a !== 1'b0) begin
      bad++;
      $display("FAIL mid_reset: got rdy=%b vld=%b, expected rdy=1 vld=0", in_ready_a, out_valid_a);
    end
    e.sum = 64'd33;
    e.err = 1'b0;
    e.cnt = 64'd2;
    sb_a.push_back(e);
    drive_req(1'b0, 64'd11, 64'd22, ok);
    wait_result(1'b0, g.sum, g.err, g.cnt, ok);
    e = sb_a.pop_front();
    total++;
    if (!ok || g.sum !== e.sum || g.err !== e.err) begin
      bad++;
      $display("FAIL after_reset: got vld=%0d sum=%0d err=%0d, expected sum=%0d err=0",
               ok, g.sum, g.err, e.sum);
    end
  endtask

  initial begin
    reset       = 1'b1;
    in_valid_a  = 1'b0;
    in_valid_b  = 1'b0;
    out_ready_a = 1'b1;
    out_ready_b = 1'b1;
    lo_in       = '0;
    hi_in       = '0;
    test_reset();
    test_ranges_reps2();
    test_ranges_reps3();
    test_random();
    test_backpressure();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
